// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   mdState_t    : multiply/divide sequencer state (RUN / MDBUSY)
//   MD_CNT_W     : width of the multi-cycle occupancy down-counter
//   REG_ZERO     : architectural register $0, never a hazard source
//   mdLoadValue  : counter preload for a new MULT/DIV (occupancy - 1)
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MDBUSY = 1'b1
    } mdState_t;

    localparam int MD_CNT_W = 6;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // The start cycle itself is the first stall cycle, so the counter
    // only has to cover the remaining occupancy.
    function automatic logic [MD_CNT_W-1:0] mdLoadValue(
        input logic isDiv,
        input int   multCycles,
        input int   divCycles
    );
        return isDiv ? MD_CNT_W'(divCycles - 1) : MD_CNT_W'(multCycles - 1);
    endfunction

endpackage

// File: rtl/md_stall_counter.sv
// Multi-cycle MULT/DIV occupancy tracker: RUN/MDBUSY state plus a
// loadable 6-bit down-counter.
// Ports:
//   Clk    in  clock
//   Rst    in  synchronous active-high reset (returns to RUN, count 0)
//   start  in  MULT/DIV present in EX (only acted on in RUN)
//   isDiv  in  selects divide occupancy for a start
//   abort  in  cancel any operation at the next edge (redirect)
//   busy   out MDBUSY with count non-zero (front of pipe must stall)
//   done   out MDBUSY with count zero (final cycle, HI/LO result valid)
//
// state  | meaning
// RUN    | no multi-cycle operation outstanding
// MDBUSY | operation in EX; count = stall cycles still to go
module md_stall_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic Clk,
    input  logic Rst,
    input  logic start,
    input  logic isDiv,
    input  logic abort,
    output logic busy,
    output logic done
);

    mdState_t              state;
    logic [MD_CNT_W-1:0]   cnt;

    always_ff @(posedge Clk) begin
        if (Rst || abort) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (start) begin
                        state <= MDBUSY;
                        cnt   <= mdLoadValue(isDiv, MULT_CYCLES, DIV_CYCLES);
                    end
                end
                MDBUSY: begin
                    // start stays high while the MD instruction is held in EX;
                    // it is deliberately not looked at here.
                    if (cnt != '0) begin
                        cnt <= cnt - MD_CNT_W'(1);
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == MDBUSY) && (cnt != '0);
    assign done = (state == MDBUSY) && (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use detection in ID,
// squash on a MEM-resolved redirect, and front-of-pipe hold for MULT/DIV.
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   IDRs, IDRt, IDUsesRt      source operands of the ID instruction
//   EXMemRead, EXWriteReg     load flag and destination of the EX instruction
//   MDStartEX, MDIsDiv        MULT/DIV present in EX, and which kind
//   MemRedirect               taken branch / jump in MEM
//   PCWrite, IFIDWrite, IDEXWrite      register / PC load enables
//   IFIDFlush, IDEXFlush, EXMEMFlush   synchronous bubble inserts
//   MDBusy, MDDone            multi-cycle op in progress / result valid pulse
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] IDRs,
    input  logic [4:0] IDRt,
    input  logic       IDUsesRt,
    input  logic       EXMemRead,
    input  logic [4:0] EXWriteReg,
    input  logic       MDStartEX,
    input  logic       MDIsDiv,
    input  logic       MemRedirect,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEXWrite,
    output logic       IFIDFlush,
    output logic       IDEXFlush,
    output logic       EXMEMFlush,
    output logic       MDBusy,
    output logic       MDDone
);

    logic mdStall;
    logic mdFinal;
    logic loadUse;

    md_stall_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) uMdCounter (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (MDStartEX),
        .isDiv (MDIsDiv),
        .abort (MemRedirect),
        .busy  (mdStall),
        .done  (mdFinal)
    );

    assign loadUse = EXMemRead && (EXWriteReg != REG_ZERO) &&
                     ((EXWriteReg == IDRs) || (IDUsesRt && (EXWriteReg == IDRt)));

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MDBusy     = 1'b0;
        MDDone     = 1'b0;

        if (Rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (MemRedirect) begin
            // Squashes everything younger than MEM, including a MULT/DIV in EX.
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (mdStall || (!mdFinal && MDStartEX)) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMFlush = 1'b1;
            MDBusy     = 1'b1;
        end else if (mdFinal) begin
            // Pipe advances; the MD instruction must not also reach MEM.
            EXMEMFlush = 1'b1;
            MDDone     = 1'b1;
        end else if (loadUse) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXFlush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] IDRs, IDRt, EXWriteReg;
    logic       IDUsesRt, EXMemRead, MDStartEX, MDIsDiv, MemRedirect;
    logic       PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MDBusy, MDDone;

    int nChecks = 0;
    int nFails  = 0;

    pipeline_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .EXMemRead(EXMemRead), .EXWriteReg(EXWriteReg), .MDStartEX(MDStartEX),
        .MDIsDiv(MDIsDiv), .MemRedirect(MemRedirect), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush), .MDBusy(MDBusy), .MDDone(MDDone)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: counts remaining stall cycles of the current MULT/DIV
    // and whether the result-valid cycle is still owed.
    int stallLeft = 0;
    bit donePending = 0;

    function automatic bit isLoadUse();
        if (!EXMemRead || EXWriteReg == 0) return 0;
        if (EXWriteReg == IDRs) return 1;
        return IDUsesRt && (EXWriteReg == IDRt);
    endfunction

    // {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXFlush,EXMEMFlush,MDBusy,MDDone}
    always @(negedge Clk) begin
        logic [7:0] e;
        int n;
        if (Rst) begin
            e = 8'b000_111_00;
            stallLeft = 0; donePending = 0;
        end else if (MemRedirect) begin
            e = 8'b111_111_00;
            stallLeft = 0; donePending = 0;
        end else if (stallLeft > 0) begin
            e = 8'b000_001_10;
            stallLeft--;
            if (stallLeft == 0) donePending = 1;
        end else if (donePending) begin
            e = 8'b111_001_01;
            donePending = 0;
        end else if (MDStartEX) begin
            e = 8'b000_001_10;
            n = MDIsDiv ? DIV_N : MULT_N;
            stallLeft = n - 1;
            donePending = (n == 1);
        end else if (isLoadUse()) begin
            e = 8'b001_010_00;
        end else begin
            e = 8'b111_000_00;
        end
        chk("outputs_vs_model",
            int'({PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MDBusy, MDDone}),
            int'(e));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Rst = 0; IDRs = 0; IDRt = 0; IDUsesRt = 0; EXMemRead = 0; EXWriteReg = 0;
        MDStartEX = 0; MDIsDiv = 0; MemRedirect = 0;
    endtask

    initial begin
        int busyCnt, doneCnt, doneAt;
        idle();
        Rst = 1;
        tick(); #5;
        chk("reset_pcwrite", int'(PCWrite), 0);
        chk("reset_flushes", int'({IFIDFlush, IDEXFlush, EXMEMFlush}), 7);
        tick(); idle(); #5;
        chk("default_enables", int'({PCWrite, IFIDWrite, IDEXWrite}), 7);

        // load-use on rs
        tick(); EXMemRead = 1; EXWriteReg = 5; IDRs = 5; #5;
        chk("loaduse_stall", int'({PCWrite, IFIDWrite, IDEXFlush}), 1);
        tick(); EXMemRead = 0; #5;
        chk("loaduse_clears", int'(PCWrite), 1);
        // load to $0, and rt match without rt use
        tick(); EXMemRead = 1; EXWriteReg = 0; IDRs = 0; #5;
        chk("load_r0_nostall", int'(PCWrite), 1);
        tick(); EXWriteReg = 7; IDRs = 3; IDRt = 7; IDUsesRt = 0; #5;
        chk("rt_unused_nostall", int'(PCWrite), 1);
        tick(); IDUsesRt = 1; #5;
        chk("rt_used_stall", int'(PCWrite), 0);
        tick(); idle();

        // multiply: held in EX while busy
        busyCnt = 0; doneCnt = 0; doneAt = -1;
        for (int i = 0; i < 7; i++) begin
            tick(); MDStartEX = (i < MULT_N); MDIsDiv = 0; #5;
            if (MDBusy) busyCnt++;
            if (MDDone) begin doneCnt++; doneAt = i; end
        end
        chk("mult_busy_cycles", busyCnt, 4);
        chk("mult_done_count", doneCnt, 1);
        chk("mult_done_at", doneAt, 4);

        // divide: start held through the done cycle, no restart
        busyCnt = 0; doneCnt = 0; doneAt = -1;
        for (int i = 0; i < 37; i++) begin
            tick(); MDStartEX = (i <= DIV_N); MDIsDiv = 1; #5;
            if (MDBusy) busyCnt++;
            if (MDDone) begin doneCnt++; doneAt = i; end
        end
        chk("div_busy_cycles", busyCnt, 32);
        chk("div_done_count", doneCnt, 1);
        chk("div_done_at", doneAt, 32);

        // redirect beats MULT start and load-use
        tick(); MemRedirect = 1; MDStartEX = 1; MDIsDiv = 0;
        EXMemRead = 1; EXWriteReg = 9; IDRs = 9; #5;
        chk("redirect_flushes", int'({IFIDFlush, IDEXFlush, EXMEMFlush}), 7);
        chk("redirect_pcwrite", int'({PCWrite, MDBusy}), 2);
        tick(); idle(); #5;
        chk("redirect_stays_run", int'({MDBusy, PCWrite}), 1);

        // reset in the middle of a divide
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); idle(); MDStartEX = (i <= 10); MDIsDiv = 1; Rst = (i == 10); #5;
            if (i == 10) chk("rst_mid_div", int'(PCWrite), 0);
            if (i == 11) chk("after_rst_idle", int'({MDBusy, MDDone, PCWrite}), 1);
            if (MDDone) doneCnt++;
        end
        chk("rst_div_no_done", doneCnt, 0);

        // randomized traffic with small register range so hazards are frequent
        for (int i = 0; i < 4000; i++) begin
            tick();
            Rst         = ($urandom_range(0, 99) == 0);
            MemRedirect = ($urandom_range(0, 19) == 0);
            MDStartEX   = ($urandom_range(0, 9) == 0);
            MDIsDiv     = ($urandom_range(0, 3) == 0);
            EXMemRead   = $urandom_range(0, 1);
            EXWriteReg  = 5'($urandom_range(0, 3));
            IDRs        = 5'($urandom_range(0, 3));
            IDRt        = 5'($urandom_range(0, 3));
            IDUsesRt    = $urandom_range(0, 1);
        end
        tick(); idle();
        tick(); #5;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards in ID.
- Squashes younger stages on a taken branch/jump resolved in MEM.
- Holds the front of the pipe for multi-cycle MULT/DIV operations in EX.
- Drives the write-enable and synchronous-flush inputs of the pipeline registers and the PC.

Parameters:
MULT_CYCLES, 4, total EX occupancy of MULT/MULTU in cycles (1..63)
DIV_CYCLES, 32, total EX occupancy of DIV/DIVU in cycles (1..63)

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  reset, synchronous, active-high
IDRs  in  5  rs field of instruction in ID
IDRt  in  5  rt field of instruction in ID
IDUsesRt  in  1  ID instruction reads rt as a source
EXMemRead  in  1  instruction in EX is a load
EXWriteReg  in  5  destination register of EX instruction
MDStartEX  in  1  EX instruction is MULT/MULTU/DIV/DIVU
MDIsDiv  in  1  qualifies MDStartEX: 1 = divide, 0 = multiply
MemRedirect  in  1  branch taken or jump in MEM (PC reloads target this cycle)
PCWrite  out  1  PC load enable
IFIDWrite  out  1  IF/ID hold when 0
IDEXWrite  out  1  ID/EX hold when 0
IFIDFlush  out  1  IF/ID loads zeros at next edge
IDEXFlush  out  1  ID/EX loads zeros (bubble)
EXMEMFlush  out  1  EX/MEM loads zeros (bubble)
MDBusy  out  1  multi-cycle op in progress
MDDone  out  1  one-cycle pulse: HI/LO result valid, write HI/LO this cycle

Behaviour:
- State: RUN, MDBUSY (registered); 6-bit down-counter Cnt. All outputs are combinational from state, Cnt and inputs.
- Rst high at an edge: state RUN, Cnt 0.
- While Rst is high: PCWrite=0, IFIDWrite=0, IDEXWrite=0, all flushes=1, MDBusy=0, MDDone=0.
- Default (RUN, no event): PCWrite=1, IFIDWrite=1, IDEXWrite=1, flushes 0, MDBusy 0, MDDone 0.

Priority in RUN, highest first:
1. MemRedirect:
   - Outputs: IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1, PCWrite=1.
   - MDStartEX is ignored (EX instruction is squashed); state stays RUN.
2. MDStartEX:
   - Next state MDBUSY; Cnt <= (MDIsDiv ? DIV_CYCLES : MULT_CYCLES) - 1.
   - This cycle: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMFlush=1, MDBusy=1.
   - Load-use detection is ignored.
3. Load-use:
   - Condition: EXMemRead && EXWriteReg!=0 && (EXWriteReg==IDRs || (IDUsesRt && EXWriteReg==IDRt)).
   - Outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly that cycle.
   - Self-clearing: the bubble removes the load from EX next cycle.

MDBUSY:
- Cnt!=0:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMFlush=1, MDBusy=1.
  - Cnt decrements.
  - MDStartEX (still high, instruction held) and load-use are ignored.
- Cnt==0:
  - Outputs: MDDone=1, MDBusy=0, default enables (the pipe advances).
  - EXMEMFlush=1 so the MD instruction does not re-enter the MEM bookkeeping twice.
  - Next state RUN.
- Net effect: a start at cycle T stalls T..T+N-1, and MDDone is high at T+N. With N=1, MDDone is high at T+1.
- MemRedirect in MDBUSY is illegal by construction, since MEM holds only bubbles. If it is asserted anyway, redirect outputs win, state returns to RUN, Cnt clears, and no MDDone is produced.

Reset mid-operation: a synchronous Rst in MDBUSY aborts the operation at the edge (RUN, Cnt 0); no MDDone.

Register 0 is never a hazard source.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state encoding RUN=1'b0, MDBUSY=1'b1
  - MD_CNT_W=6
  - REG_ZERO=5'd0
- Sub-module md_stall_counter:
  - loadable 6-bit down-counter plus RUN/MDBUSY state
  - inputs: start, is_div, abort
  - outputs: busy, done
- Top level holds hazard comparators and the output priority mux.

Test Plan:
1. Load-use: lw $5 in EX (EXMemRead=1, EXWriteReg=5), ID IDRs=5 -> one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle defaults.
2. Load to $0 or IDUsesRt=0 with IDRt match -> no stall; PCWrite=1 throughout.
3. MDStartEX=1, MDIsDiv=0, MULT_CYCLES=4 at cycle T -> stall T..T+3, MDDone=1 only at T+4, MDBusy=1 at T..T+3.
4. DIV_CYCLES=32: MDStartEX held high across busy -> exactly 32 stall cycles, single MDDone at T+32, no restart.
5. MemRedirect=1 with MDStartEX=1 and load-use true same cycle -> all three flushes=1, PCWrite=1, state stays RUN.
6. Rst pulsed at T+10 of a divide -> at T+11 state RUN, MDBusy=0, no MDDone; enables return to 1 once Rst drops.
